// File: rtl/e203_ifu_jalr_sched_pkg.sv
// Shared types for the IFU branch-target scheduler.
// Optional feature macro: E203_JALR_X1_FWD_EN.
package e203_jalr_sched_pkg;

  localparam int XLEN    = 32;
  localparam int PC_W    = XLEN;
  localparam int RFIDX_W = 5;

  localparam logic [RFIDX_W-1:0] X0 = 5'd0;
  localparam logic [RFIDX_W-1:0] X1 = 5'd1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DEP,
    REQ,
    RDATA
  } state_e;

  typedef enum logic [1:0] {
    BASE_PC,
    BASE_ZERO,
    BASE_X1,
    BASE_RS1
  } base_e;

endpackage

// File: rtl/e203_ifu_jalr_sched_if.sv
// IR / mini-decoder / RF-port / prediction bundle of the scheduler.
// master drives the IR side, slave is the scheduler.
interface e203_ifu_jalr_sched_if;
  import e203_jalr_sched_pkg::*;

  logic               ir_valid;
  logic               ir_ready;
  logic [PC_W-1:0]    ir_pc;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic               oitf_empty;
  logic               exu_ir_rdwen;
  logic [RFIDX_W-1:0] exu_ir_rdidx;
  logic [XLEN-1:0]    rf_x1;
  logic               bpu2rf_req;
  logic               rf2bpu_gnt;
  logic [XLEN-1:0]    rf2bpu_rs1;
  logic               prdt_vld;
  logic               prdt_taken;
  logic [PC_W-1:0]    prdt_pc;

  modport master (
    output ir_valid, ir_pc,
    output dec_jal, dec_jalr, dec_bxx,
    output dec_jalr_rs1idx, dec_bjp_imm,
    output oitf_empty, exu_ir_rdwen,
    output exu_ir_rdidx, rf_x1,
    output rf2bpu_gnt, rf2bpu_rs1,
    input  ir_ready, bpu2rf_req,
    input  prdt_vld, prdt_taken, prdt_pc
  );

  modport slave (
    input  ir_valid, ir_pc,
    input  dec_jal, dec_jalr, dec_bxx,
    input  dec_jalr_rs1idx, dec_bjp_imm,
    input  oitf_empty, exu_ir_rdwen,
    input  exu_ir_rdidx, rf_x1,
    input  rf2bpu_gnt, rf2bpu_rs1,
    output ir_ready, bpu2rf_req,
    output prdt_vld, prdt_taken, prdt_pc
  );

endinterface

// File: rtl/e203_ifu_bjp_tgt_adder.sv
// Branch target adder: base select + immediate add.
// jalr targets get bit0 cleared; jal/bxx targets pass through.
module e203_ifu_bjp_tgt_adder
  import e203_jalr_sched_pkg::*;
(
  input  base_e           sel,
  input  logic            jalr,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] x1,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  output logic [PC_W-1:0] tgt
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  always_comb begin
    base = '0;
    unique case (sel)
      BASE_PC:   base = pc;
      BASE_ZERO: base = '0;
      BASE_X1:   base = x1;
      BASE_RS1:  base = rs1;
      default:   base = '0;
    endcase
    sum = base + imm;
    tgt = jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  end

endmodule

// File: rtl/e203_ifu_jalr_sched.sv
// Resolves bjp predictions; jalr-xN waits for hazards, then reads RF.
// Optional: E203_JALR_X1_FWD_EN enables the forwarded-x1 fast path.
module e203_ifu_jalr_sched
  import e203_jalr_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  e203_ifu_jalr_sched_if.slave  bus
);

  state_e          state_q;
  state_e          state_d;
  base_e           sel;
  logic            ready;
  logic            req;
  logic            taken;
  logic            bjp;
  logic            is_x0;
  logic            x1_fwd;
  logic            dep;
  logic            vld;
  logic [XLEN-1:0] x1_val;
  logic [PC_W-1:0] tgt;

`ifdef E203_JALR_X1_FWD_EN
  assign x1_fwd = bus.dec_jalr_rs1idx == X1;
  assign x1_val = bus.rf_x1;
`else
  logic unused_x1;
  assign unused_x1 = ^bus.rf_x1;
  assign x1_fwd    = 1'b0;
  assign x1_val    = '0;
`endif

  assign bjp   = bus.dec_jal | bus.dec_jalr
               | bus.dec_bxx;
  assign is_x0 = bus.dec_jalr_rs1idx == X0;
  assign dep   = ~bus.oitf_empty
               | (bus.exu_ir_rdwen
                 & (bus.exu_ir_rdidx
                    == bus.dec_jalr_rs1idx));

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    req     = 1'b0;
    taken   = 1'b0;
    sel     = BASE_PC;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.ir_valid & bjp) begin
          unique case (1'b1)
            bus.dec_jal: taken = 1'b1;
            bus.dec_bxx:
              taken = bus.dec_bjp_imm[XLEN-1];
            bus.dec_jalr: begin
              if (is_x0) begin
                taken = 1'b1;
                sel   = BASE_ZERO;
              end else if (x1_fwd & ~dep) begin
                taken = 1'b1;
                sel   = BASE_X1;
              end else begin
                ready   = 1'b0;
                state_d = dep ? WAIT_DEP : REQ;
              end
            end
            default: ready = 1'b1;
          endcase
        end
      end
      WAIT_DEP: begin
        if (~dep) begin
          if (x1_fwd) begin
            ready   = 1'b1;
            taken   = 1'b1;
            sel     = BASE_X1;
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (bus.rf2bpu_gnt) state_d = RDATA;
      end
      RDATA: begin
        ready   = 1'b1;
        taken   = 1'b1;
        sel     = BASE_RS1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush beats any in-flight grant or resolution
    if (flush) begin
      state_d = IDLE;
      ready   = 1'b0;
      req     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  e203_ifu_bjp_tgt_adder u_adder (
    .sel  (sel),
    .jalr (bus.dec_jalr),
    .pc   (bus.ir_pc),
    .x1   (x1_val),
    .rs1  (bus.rf2bpu_rs1),
    .imm  (bus.dec_bjp_imm),
    .tgt  (tgt)
  );

  assign vld = bus.ir_valid & bjp & ready & ~rst;

  assign bus.ir_ready   = ready & ~rst;
  assign bus.bpu2rf_req = req & ~rst;
  assign bus.prdt_vld   = vld;
  assign bus.prdt_taken = taken & vld;
  assign bus.prdt_pc    = rst ? '0 : tgt;

endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// Bench for e203_ifu_jalr_sched: vector table, corner sequences,
// random traffic vs. an instruction-history reference model.
module tb_e203_ifu_jalr_sched;

`ifdef E203_JALR_X1_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  e203_ifu_jalr_sched_if bus();

  e203_ifu_jalr_sched dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        v;
    logic        jal;
    logic        jalr;
    logic        bxx;
    logic [4:0]  idx;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] x1;
    logic        oitf;
    logic        e_rdy;
    logic        e_vld;
    logic        e_tk;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic fl, logic v, logic jal,
    logic jalr, logic bxx, logic [4:0] idx,
    logic [31:0] pc, logic [31:0] imm,
    logic [31:0] x1, logic oitf,
    logic e_rdy, logic e_vld, logic e_tk,
    logic [31:0] e_pc);
    vec_t r;
    r.fl = fl; r.v = v; r.jal = jal;
    r.jalr = jalr; r.bxx = bxx; r.idx = idx;
    r.pc = pc; r.imm = imm; r.x1 = x1;
    r.oitf = oitf; r.e_rdy = e_rdy;
    r.e_vld = e_vld; r.e_tk = e_tk;
    r.e_pc = e_pc;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic idle_in();
    flush = 1'b0;
    bus.ir_valid = 1'b0;
    bus.ir_pc = '0;
    bus.dec_jal = 1'b0;
    bus.dec_jalr = 1'b0;
    bus.dec_bxx = 1'b0;
    bus.dec_jalr_rs1idx = '0;
    bus.dec_bjp_imm = '0;
    bus.oitf_empty = 1'b1;
    bus.exu_ir_rdwen = 1'b0;
    bus.exu_ir_rdidx = '0;
    bus.rf_x1 = '0;
    bus.rf2bpu_gnt = 1'b0;
    bus.rf2bpu_rs1 = '0;
  endtask

  task automatic jalr_in(input logic [4:0] idx,
                         input logic [31:0] imm);
    bus.ir_valid = 1'b1;
    bus.dec_jalr = 1'b1;
    bus.dec_jalr_rs1idx = idx;
    bus.dec_bjp_imm = imm;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // reference model state: history of the instr held in IR
  logic [31:0] m_pc, m_imm;
  logic        m_v, m_jal, m_jalr, m_bxx;
  logic [4:0]  m_idx;
  bit          seen_clear, granted, need_new;

  initial begin
    idle_in();
    rst = 1'b1;
    bus.ir_valid = 1'b1;
    bus.dec_jal = 1'b1;
    bus.ir_pc = 32'h100;
    bus.dec_bjp_imm = 32'h20;
    repeat (2) tick();
    #1;
    chk("rst_ready", 32'(bus.ir_ready), 0);
    chk("rst_vld", 32'(bus.prdt_vld), 0);
    chk("rst_req", 32'(bus.bpu2rf_req), 0);
    chk("rst_pc", bus.prdt_pc, 0);
    tick();
    rst = 1'b0;
    idle_in();

    vecs.push_back(mk(0,1,1,0,0,0,32'h100,
      32'h20,0,1, 1,1,1,32'h120));
    vecs.push_back(mk(0,1,0,0,1,0,32'h200,
      32'hFFFFFFF0,0,1, 1,1,1,32'h1F0));
    vecs.push_back(mk(0,1,0,0,1,0,32'h200,
      32'h10,0,1, 1,1,0,32'h210));
    vecs.push_back(mk(0,1,0,1,0,0,32'h300,
      32'h1235,0,1, 1,1,1,32'h1234));
    vecs.push_back(mk(0,1,1,0,0,0,32'hFFFFFFF0,
      32'h21,0,1, 1,1,1,32'h11));
    vecs.push_back(mk(0,1,0,0,0,0,32'h400,
      32'h8,0,1, 1,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,32'h400,
      32'h8,0,1, 1,0,0,0));
    vecs.push_back(mk(1,1,0,1,0,5,32'h500,
      32'h8,0,1, 0,0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0,32'h500,
      32'h8,0,1, 0,0,0,0));
    vecs.push_back(mk(0,1,0,1,0,0,32'h600,
      32'hFFFFFFFF,0,0, 1,1,1,32'hFFFFFFFE));
`ifdef E203_JALR_X1_FWD_EN
    vecs.push_back(mk(0,1,0,1,0,1,32'h700,
      32'h7,32'h80,1, 1,1,1,32'h86));
`else
    vecs.push_back(mk(1,1,0,1,0,1,32'h700,
      32'h7,32'h80,1, 0,0,0,0));
`endif

    foreach (vecs[i]) begin
      tick();
      idle_in();
      flush = vecs[i].fl;
      bus.ir_valid = vecs[i].v;
      bus.dec_jal = vecs[i].jal;
      bus.dec_jalr = vecs[i].jalr;
      bus.dec_bxx = vecs[i].bxx;
      bus.dec_jalr_rs1idx = vecs[i].idx;
      bus.ir_pc = vecs[i].pc;
      bus.dec_bjp_imm = vecs[i].imm;
      bus.rf_x1 = vecs[i].x1;
      bus.oitf_empty = vecs[i].oitf;
      #1;
      chk($sformatf("vec%0d_ready", i),
          32'(bus.ir_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_vld", i),
          32'(bus.prdt_vld), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_req", i),
          32'(bus.bpu2rf_req), 0);
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_taken", i),
            32'(bus.prdt_taken),
            32'(vecs[i].e_tk));
        chk($sformatf("vec%0d_pc", i),
            bus.prdt_pc, vecs[i].e_pc);
      end
    end

    // jalr x5: grant withheld two cycles
    tick(); idle_in();
    jalr_in(5, 32'h4);
    bus.rf2bpu_rs1 = 32'h1001;
    #1;
    chk("x5_c0_ready", 32'(bus.ir_ready), 0);
    chk("x5_c0_req", 32'(bus.bpu2rf_req), 0);
    tick(); #1;
    chk("x5_c1_req", 32'(bus.bpu2rf_req), 1);
    tick(); #1;
    chk("x5_c2_req", 32'(bus.bpu2rf_req), 1);
    tick(); bus.rf2bpu_gnt = 1'b1; #1;
    chk("x5_c3_req", 32'(bus.bpu2rf_req), 1);
    chk("x5_c3_ready", 32'(bus.ir_ready), 0);
    tick(); bus.rf2bpu_gnt = 1'b0; #1;
    chk("x5_c4_vld", 32'(bus.prdt_vld), 1);
    chk("x5_c4_ready", 32'(bus.ir_ready), 1);
    chk("x5_c4_taken", 32'(bus.prdt_taken), 1);
    chk("x5_c4_pc", bus.prdt_pc, 32'h1004);
    chk("x5_c4_req", 32'(bus.bpu2rf_req), 0);

    // jalr x1 behind an EXU write of x1
    tick(); idle_in();
    jalr_in(1, 32'h8);
    bus.rf_x1 = 32'h80;
    bus.exu_ir_rdwen = 1'b1;
    bus.exu_ir_rdidx = 5'd1;
    #1;
    chk("x1_c0_ready", 32'(bus.ir_ready), 0);
    tick(); #1;
    chk("x1_c1_ready", 32'(bus.ir_ready), 0);
    tick(); bus.exu_ir_rdwen = 1'b0; #1;
`ifdef E203_JALR_X1_FWD_EN
    chk("x1_c2_ready", 32'(bus.ir_ready), 1);
    chk("x1_c2_vld", 32'(bus.prdt_vld), 1);
    chk("x1_c2_pc", bus.prdt_pc, 32'h88);
`else
    chk("x1_c2_ready", 32'(bus.ir_ready), 0);
    chk("x1_c2_req", 32'(bus.bpu2rf_req), 0);
    tick(); #1;
    chk("x1_c3_req", 32'(bus.bpu2rf_req), 1);
    tick(); flush = 1'b1; #1;
    chk("x1_fl_req", 32'(bus.bpu2rf_req), 0);
`endif

    // flush together with grant in REQ
    tick(); idle_in();
    jalr_in(5, 32'h4);
    #1;
    tick(); #1;
    chk("fg_req", 32'(bus.bpu2rf_req), 1);
    tick(); bus.rf2bpu_gnt = 1'b1; flush = 1'b1;
    #1;
    chk("fg_req0", 32'(bus.bpu2rf_req), 0);
    chk("fg_ready", 32'(bus.ir_ready), 0);
    chk("fg_vld", 32'(bus.prdt_vld), 0);
    tick(); idle_in(); #1;
    chk("fg_idle_rdy", 32'(bus.ir_ready), 1);
    chk("fg_idle_vld", 32'(bus.prdt_vld), 0);
    // stray grant in IDLE must not skip REQ
    tick(); jalr_in(5, 32'h4);
    bus.rf2bpu_gnt = 1'b1; #1;
    chk("sg_req", 32'(bus.bpu2rf_req), 0);
    tick(); bus.rf2bpu_gnt = 1'b0; #1;
    chk("sg_req1", 32'(bus.bpu2rf_req), 1);
    chk("sg_ready", 32'(bus.ir_ready), 0);
    tick(); bus.rf2bpu_gnt = 1'b1; #1;
    // flush while in RDATA
    tick(); bus.rf2bpu_gnt = 1'b0; flush = 1'b1;
    #1;
    chk("fr_vld", 32'(bus.prdt_vld), 0);
    chk("fr_ready", 32'(bus.ir_ready), 0);
    tick(); idle_in(); #1;
    chk("fr_idle", 32'(bus.ir_ready), 1);

    // reset while in RDATA
    tick(); jalr_in(7, 32'h10);
    bus.rf2bpu_rs1 = 32'h2000; #1;
    tick(); bus.rf2bpu_gnt = 1'b1; #1;
    tick(); bus.rf2bpu_gnt = 1'b0; rst = 1'b1;
    #1;
    chk("rr_ready", 32'(bus.ir_ready), 0);
    chk("rr_vld", 32'(bus.prdt_vld), 0);
    chk("rr_taken", 32'(bus.prdt_taken), 0);
    chk("rr_req", 32'(bus.bpu2rf_req), 0);
    chk("rr_pc", bus.prdt_pc, 0);
    tick(); rst = 1'b0; idle_in(); #1;
    chk("rr_idle", 32'(bus.ir_ready), 1);
    chk("rr_req0", 32'(bus.bpu2rf_req), 0);

    // random traffic vs reference model
    need_new = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      logic        dep, e_rdy, e_vld, e_tk, e_req;
      logic [31:0] e_pc;
      int          kind;
      tick();
      if (need_new) begin
        int r;
        m_v = ($urandom % 8) != 0;
        m_jal = 0; m_jalr = 0; m_bxx = 0;
        m_pc = $urandom;
        m_imm = $urandom;
        m_idx = 5'($urandom_range(2, 3));
        r = $urandom % 7;
        case (r)
          0: m_jal = 1;
          1: m_bxx = 1;
          2: begin m_jalr = 1; m_idx = 0; end
          3: begin m_jalr = 1; m_idx = 1; end
          4, 5: m_jalr = 1;
          default: ;
        endcase
        seen_clear = 0;
        granted = 0;
      end
      flush = ($urandom % 25) == 0;
      bus.ir_valid = m_v;
      bus.ir_pc = m_pc;
      bus.dec_jal = m_jal;
      bus.dec_jalr = m_jalr;
      bus.dec_bxx = m_bxx;
      bus.dec_jalr_rs1idx = m_idx;
      bus.dec_bjp_imm = m_imm;
      bus.oitf_empty = ($urandom % 4) != 0;
      bus.exu_ir_rdwen = $urandom % 2;
      bus.exu_ir_rdidx = 5'($urandom % 4);
      bus.rf_x1 = $urandom;
      bus.rf2bpu_gnt = $urandom % 2;
      bus.rf2bpu_rs1 = $urandom;
      #1;
      dep = !bus.oitf_empty
          || (bus.exu_ir_rdwen
              && bus.exu_ir_rdidx == m_idx);
      if (!m_v || !(m_jal || m_jalr || m_bxx))
        kind = 0;
      else if (!m_jalr || m_idx == 0)
        kind = 1;
      else if (m_idx == 1 && FWD)
        kind = 2;
      else
        kind = 3;
      e_rdy = 0; e_vld = 0; e_tk = 0;
      e_req = 0; e_pc = 0;
      if (!flush) begin
        case (kind)
          0: e_rdy = 1;
          1: begin
            e_rdy = 1; e_vld = 1;
            if (m_jal) begin
              e_tk = 1; e_pc = m_pc + m_imm;
            end else if (m_bxx) begin
              e_tk = m_imm[31];
              e_pc = m_pc + m_imm;
            end else begin
              e_tk = 1;
              e_pc = m_imm & ~32'h1;
            end
          end
          2: if (!dep) begin
            e_rdy = 1; e_vld = 1; e_tk = 1;
            e_pc = (bus.rf_x1 + m_imm) & ~32'h1;
          end
          default: if (granted) begin
            e_rdy = 1; e_vld = 1; e_tk = 1;
            e_pc = (bus.rf2bpu_rs1 + m_imm)
                 & ~32'h1;
          end else begin
            e_req = seen_clear;
          end
        endcase
      end
      chk($sformatf("rnd%0d_ready", c),
          32'(bus.ir_ready), 32'(e_rdy));
      chk($sformatf("rnd%0d_vld", c),
          32'(bus.prdt_vld), 32'(e_vld));
      chk($sformatf("rnd%0d_req", c),
          32'(bus.bpu2rf_req), 32'(e_req));
      if (e_vld) begin
        chk($sformatf("rnd%0d_taken", c),
            32'(bus.prdt_taken), 32'(e_tk));
        chk($sformatf("rnd%0d_pc", c),
            bus.prdt_pc, e_pc);
      end
      if (flush || e_rdy) begin
        need_new = 1;
      end else begin
        need_new = 0;
        if (kind == 3) begin
          if (e_req && bus.rf2bpu_gnt)
            granted = 1;
          if (!dep) seen_clear = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
